// File: rtl/timer1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer1_pkg
// Description : Shared definitions for the Timer/Counter1 access controller.
//               Holds the clock-select (CS) encodings, the TEMP-byte state
//               type and the default I/O addresses of the Timer1 registers.
// Revision    : 1.0 - initial release
// ============================================================================
package timer1_pkg;

    // TCCR1B clock-select encodings (CS12:CS10)
    localparam logic [2:0] CS_STOP     = 3'b000;
    localparam logic [2:0] CS_DIV1     = 3'b001;
    localparam logic [2:0] CS_DIV8     = 3'b010;
    localparam logic [2:0] CS_DIV64    = 3'b011;
    localparam logic [2:0] CS_DIV256   = 3'b100;
    localparam logic [2:0] CS_DIV1024  = 3'b101;
    localparam logic [2:0] CS_EXT_FALL = 3'b110;
    localparam logic [2:0] CS_EXT_RISE = 3'b111;

    // Tracks whether a high byte has been staged in TEMP
    typedef enum logic [0:0] {
        TEMP_EMPTY  = 1'b0,
        TEMP_LOADED = 1'b1
    } temp_state_t;

    // Default I/O addresses
    localparam logic [5:0] DEFAULT_ADDR_OCR1AL = 6'h2A;
    localparam logic [5:0] DEFAULT_ADDR_OCR1AH = 6'h2B;
    localparam logic [5:0] DEFAULT_ADDR_TCNT1L = 6'h2C;
    localparam logic [5:0] DEFAULT_ADDR_TCNT1H = 6'h2D;
    localparam logic [5:0] DEFAULT_ADDR_TCCR1B = 6'h2E;

endpackage
`default_nettype wire

// File: rtl/timer1_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer1_prescaler
// Description : Free-running 10-bit prescaler producing the raw Timer1 count
//               tick for the selected clock source.
//               Optional macro TIMER1_EXT_CLK_EN enables the external T1 pin
//               source (CS=110 falling edge, CS=111 rising edge); without it
//               those encodings behave as stopped and t1_pin is unused.
// Ports       : sysClock  - system clock
//               reset     - synchronous active-high reset
//               cs        - clock select (TCCR1B[2:0])
//               t1_pin    - asynchronous external clock pin
//               raw_tick  - single-cycle tick before preload masking
// Revision    : 1.0 - initial release
// ============================================================================
module timer1_prescaler
    import timer1_pkg::*;
(
    input  logic       sysClock,
    input  logic       reset,
    input  logic [2:0] cs,
    input  logic       t1_pin,
    output logic       raw_tick
);

    logic [9:0] r_prescale;
    logic       w_ext_fall;
    logic       w_ext_rise;

    // Cleared only by reset; a CS change does not restart the divider
    always_ff @(posedge sysClock) begin
        if (reset) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 10'd1;
        end
    end

`ifdef TIMER1_EXT_CLK_EN
    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // Two-flop synchroniser, then a registered edge detect: a pin edge
    // appears as a tick on the third cycle after it is first sampled.
    always_ff @(posedge sysClock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= t1_pin;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
            r_fall  <= ~r_sync2 & r_prev;
        end
    end

    assign w_ext_fall = r_fall;
    assign w_ext_rise = r_rise;
`else
    logic w_unused_t1_pin;

    assign w_unused_t1_pin = t1_pin;
    assign w_ext_fall      = 1'b0;
    assign w_ext_rise      = 1'b0;
`endif

    // Divided ticks fire when the relevant low bits wrap to zero
    always_comb begin
        raw_tick = 1'b0;
        case (cs)
            CS_STOP:     raw_tick = 1'b0;
            CS_DIV1:     raw_tick = 1'b1;
            CS_DIV8:     raw_tick = (r_prescale[2:0] == 3'd0);
            CS_DIV64:    raw_tick = (r_prescale[5:0] == 6'd0);
            CS_DIV256:   raw_tick = (r_prescale[7:0] == 8'd0);
            CS_DIV1024:  raw_tick = (r_prescale == 10'd0);
            CS_EXT_FALL: raw_tick = w_ext_fall;
            CS_EXT_RISE: raw_tick = w_ext_rise;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/timer1_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : timer1_access_controller
// Description : CPU I/O-bus front end for the 16-bit Timer/Counter1. Provides
//               the shared TEMP byte for atomic TCNT1/OCR1A accesses, holds
//               OCR1A and TCCR1B[2:0], drives the timer preload and produces
//               the prescaled count tick.
//               Optional macro TIMER1_EXT_CLK_EN (in timer1_prescaler)
//               enables the external T1 clock source.
// Ports       : sysClock/reset      - clock, synchronous active-high reset
//               io_addr/io_wdata    - I/O bus address and write data
//               io_we/io_re         - one-cycle write / read strobes
//               io_rdata            - registered read data
//               tcnt_count          - live timer count
//               TCNT1H/L_input      - preload bytes, TCNT_write_enable strobe
//               OCR1AH/L_input      - compare register bytes
//               count_tick          - one-cycle count enable
//               t1_pin              - external clock pin
// Revision    : 1.0 - initial release
// ============================================================================
module timer1_access_controller
    import timer1_pkg::*;
#(
    parameter logic [5:0] ADDR_OCR1AL = DEFAULT_ADDR_OCR1AL,
    parameter logic [5:0] ADDR_OCR1AH = DEFAULT_ADDR_OCR1AH,
    parameter logic [5:0] ADDR_TCNT1L = DEFAULT_ADDR_TCNT1L,
    parameter logic [5:0] ADDR_TCNT1H = DEFAULT_ADDR_TCNT1H,
    parameter logic [5:0] ADDR_TCCR1B = DEFAULT_ADDR_TCCR1B
) (
    input  logic        sysClock,
    input  logic        reset,
    input  logic [5:0]  io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [7:0]  io_rdata,
    input  logic [15:0] tcnt_count,
    output logic [7:0]  TCNT1H_input,
    output logic [7:0]  TCNT1L_input,
    output logic        TCNT_write_enable,
    output logic [7:0]  OCR1AH_input,
    output logic [7:0]  OCR1AL_input,
    output logic        count_tick,
    input  logic        t1_pin
);

    logic        w_sel_ocrl;
    logic        w_sel_ocrh;
    logic        w_sel_tcntl;
    logic        w_sel_tcnth;
    logic        w_sel_tccr;
    logic        w_wr_high;
    logic        w_wr_low;
    logic        w_raw_tick;

    logic [7:0]  r_temp;
    logic [15:0] r_ocr1a;
    logic [2:0]  r_cs;
    logic [7:0]  r_rdata;
    logic [7:0]  r_tcnt_h;
    logic [7:0]  r_tcnt_l;
    logic        r_tcnt_we;

    temp_state_t r_temp_state;
    temp_state_t w_temp_state_next;

    assign w_sel_ocrl  = (io_addr == ADDR_OCR1AL);
    assign w_sel_ocrh  = (io_addr == ADDR_OCR1AH);
    assign w_sel_tcntl = (io_addr == ADDR_TCNT1L);
    assign w_sel_tcnth = (io_addr == ADDR_TCNT1H);
    assign w_sel_tccr  = (io_addr == ADDR_TCCR1B);

    assign w_wr_high = io_we & (w_sel_tcnth | w_sel_ocrh);
    assign w_wr_low  = io_we & (w_sel_tcntl | w_sel_ocrl);

    // TEMP staging state
    always_ff @(posedge sysClock) begin
        if (reset) begin
            r_temp_state <= TEMP_EMPTY;
        end else begin
            r_temp_state <= w_temp_state_next;
        end
    end

    always_comb begin
        w_temp_state_next = r_temp_state;
        if (w_wr_high) begin
            w_temp_state_next = TEMP_LOADED;
        end else if (w_wr_low) begin
            w_temp_state_next = TEMP_EMPTY;
        end
    end

    // Register file and TEMP datapath. A simultaneous write and read is
    // treated as a write only. TEMP is not cleared by a low-byte write so a
    // staged high byte can be reused.
    always_ff @(posedge sysClock) begin
        if (reset) begin
            r_temp    <= '0;
            r_ocr1a   <= '0;
            r_cs      <= '0;
            r_rdata   <= '0;
            r_tcnt_h  <= '0;
            r_tcnt_l  <= '0;
            r_tcnt_we <= 1'b0;
        end else begin
            r_tcnt_we <= 1'b0;
            if (io_we) begin
                if (w_sel_tcnth || w_sel_ocrh) begin
                    r_temp <= io_wdata;
                end
                if (w_sel_tcntl) begin
                    r_tcnt_h  <= r_temp;
                    r_tcnt_l  <= io_wdata;
                    r_tcnt_we <= 1'b1;
                end
                if (w_sel_ocrl) begin
                    r_ocr1a <= {r_temp, io_wdata};
                end
                if (w_sel_tccr) begin
                    r_cs <= io_wdata[2:0];
                end
            end else if (io_re) begin
                if (w_sel_tcntl) begin
                    // Snapshot the high byte alongside the low byte
                    r_rdata <= tcnt_count[7:0];
                    r_temp  <= tcnt_count[15:8];
                end else if (w_sel_tcnth) begin
                    r_rdata <= r_temp;
                end else if (w_sel_ocrh) begin
                    r_rdata <= r_ocr1a[15:8];
                end else if (w_sel_ocrl) begin
                    r_rdata <= r_ocr1a[7:0];
                end else if (w_sel_tccr) begin
                    r_rdata <= {5'b0, r_cs};
                end
            end
        end
    end

    timer1_prescaler u_prescaler (
        .sysClock (sysClock),
        .reset    (reset),
        .cs       (r_cs),
        .t1_pin   (t1_pin),
        .raw_tick (w_raw_tick)
    );

    // Never increment in the same cycle the preload lands
    assign count_tick        = w_raw_tick & ~r_tcnt_we;

    assign io_rdata          = r_rdata;
    assign TCNT1H_input      = r_tcnt_h;
    assign TCNT1L_input      = r_tcnt_l;
    assign TCNT_write_enable = r_tcnt_we;
    assign OCR1AH_input      = r_ocr1a[15:8];
    assign OCR1AL_input      = r_ocr1a[7:0];

endmodule
`default_nettype wire

// File: tb/tb_timer1_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer1_access_controller
// Description : Self-checking bench for timer1_access_controller using
//               randomised bus traffic against a register-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_timer1_access_controller;

    localparam logic [5:0] A_OCRL = 6'h2A;
    localparam logic [5:0] A_OCRH = 6'h2B;
    localparam logic [5:0] A_TL   = 6'h2C;
    localparam logic [5:0] A_TH   = 6'h2D;
    localparam logic [5:0] A_TCCR = 6'h2E;

    logic        sysClock;
    logic        reset;
    logic [5:0]  io_addr;
    logic [7:0]  io_wdata;
    logic        io_we;
    logic        io_re;
    logic [7:0]  io_rdata;
    logic [15:0] tcnt_count;
    logic [7:0]  TCNT1H_input;
    logic [7:0]  TCNT1L_input;
    logic        TCNT_write_enable;
    logic [7:0]  OCR1AH_input;
    logic [7:0]  OCR1AL_input;
    logic        count_tick;
    logic        t1_pin;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    // Reference model state
    logic [7:0]  m_temp;
    logic [15:0] m_ocr;
    logic [2:0]  m_cs;
    logic [7:0]  m_rdata;
    logic [7:0]  m_pre_h;
    logic [7:0]  m_pre_l;
    bit          m_we;

    timer1_access_controller dut (
        .sysClock          (sysClock),
        .reset             (reset),
        .io_addr           (io_addr),
        .io_wdata          (io_wdata),
        .io_we             (io_we),
        .io_re             (io_re),
        .io_rdata          (io_rdata),
        .tcnt_count        (tcnt_count),
        .TCNT1H_input      (TCNT1H_input),
        .TCNT1L_input      (TCNT1L_input),
        .TCNT_write_enable (TCNT_write_enable),
        .OCR1AH_input      (OCR1AH_input),
        .OCR1AL_input      (OCR1AL_input),
        .count_tick        (count_tick),
        .t1_pin            (t1_pin)
    );

    initial sysClock = 1'b0;
    always #5 sysClock = ~sysClock;

    // Cycles elapsed since reset released (the prescaler's expected value)
    always @(posedge sysClock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic bit exp_tick(logic [2:0] cs, int unsigned c);
        case (cs)
            3'd1:    return 1'b1;
            3'd2:    return (c % 8) == 0;
            3'd3:    return (c % 64) == 0;
            3'd4:    return (c % 256) == 0;
            3'd5:    return (c % 1024) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        m_temp = 0; m_ocr = 0; m_cs = 0; m_rdata = 0;
        m_pre_h = 0; m_pre_l = 0; m_we = 0;
    endtask

    task automatic model_access(bit we, bit re, logic [5:0] a, logic [7:0] d, logic [15:0] cnt);
        m_we = 0;
        if (we) begin
            if (a == A_TH || a == A_OCRH) m_temp = d;
            else if (a == A_TL) begin m_pre_h = m_temp; m_pre_l = d; m_we = 1; end
            else if (a == A_OCRL) m_ocr = {m_temp, d};
            else if (a == A_TCCR) m_cs = d[2:0];
        end else if (re) begin
            if (a == A_TL) begin m_rdata = cnt[7:0]; m_temp = cnt[15:8]; end
            else if (a == A_TH)   m_rdata = m_temp;
            else if (a == A_OCRH) m_rdata = m_ocr[15:8];
            else if (a == A_OCRL) m_rdata = m_ocr[7:0];
            else if (a == A_TCCR) m_rdata = {5'b0, m_cs};
        end
    endtask

    // One bus cycle; returns #1 after the capturing edge
    task automatic bus_op(bit we, bit re, logic [5:0] a, logic [7:0] d);
        @(negedge sysClock);
        io_we = we; io_re = re; io_addr = a; io_wdata = d;
        @(posedge sysClock);
        model_access(we, re, a, d, tcnt_count);
        #1;
        io_we = 0; io_re = 0;
    endtask

    task automatic idle_cycle();
        @(negedge sysClock);
        @(posedge sysClock);
        m_we = 0;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge sysClock);
        reset = 1;
        repeat (2) @(posedge sysClock);
        model_clear();
        #1;
    endtask

    task automatic release_reset();
        @(negedge sysClock);
        reset = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (io_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", io_rdata); end
        n_checks++; if (TCNT1H_input !== 8'h00) begin n_fail++; $display("FAIL reset_tcnth: got %h want 00", TCNT1H_input); end
        n_checks++; if (TCNT1L_input !== 8'h00) begin n_fail++; $display("FAIL reset_tcntl: got %h want 00", TCNT1L_input); end
        n_checks++; if (TCNT_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", TCNT_write_enable); end
        n_checks++; if ({OCR1AH_input, OCR1AL_input} !== 16'h0000) begin n_fail++; $display("FAIL reset_ocr: got %h want 0000", {OCR1AH_input, OCR1AL_input}); end
        n_checks++; if (count_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", count_tick); end
        release_reset();
        bus_op(0, 1, A_TH, 8'h00);
        n_checks++; if (io_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_temp: got %h want 00", io_rdata); end
    endtask

    task automatic test_tcnt_write();
        bus_op(1, 0, A_TH, 8'h12);
        n_checks++; if (TCNT_write_enable !== 1'b0 || TCNT1H_input !== 8'h00) begin n_fail++; $display("FAIL tcnth_only: we=%b h=%h want we=0 h=00", TCNT_write_enable, TCNT1H_input); end
        bus_op(1, 0, A_TL, 8'h34);
        n_checks++; if (TCNT_write_enable !== 1'b1) begin n_fail++; $display("FAIL tcnt_we_on: got %b want 1", TCNT_write_enable); end
        n_checks++; if ({TCNT1H_input, TCNT1L_input} !== 16'h1234) begin n_fail++; $display("FAIL tcnt_preload: got %h want 1234", {TCNT1H_input, TCNT1L_input}); end
        idle_cycle();
        n_checks++; if (TCNT_write_enable !== 1'b0) begin n_fail++; $display("FAIL tcnt_we_off: got %b want 0", TCNT_write_enable); end
        // Random pairs; sometimes skip the high byte so TEMP is reused
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) != 0) bus_op(1, 0, A_TH, 8'($urandom));
            bus_op(1, 0, A_TL, 8'($urandom));
            n_checks++; if (TCNT_write_enable !== 1'b1 || {TCNT1H_input, TCNT1L_input} !== {m_pre_h, m_pre_l}) begin n_fail++; $display("FAIL tcnt_rand: we=%b val=%h want we=1 val=%h", TCNT_write_enable, {TCNT1H_input, TCNT1L_input}, {m_pre_h, m_pre_l}); end
        end
    endtask

    task automatic test_tcnt_read();
        tcnt_count = 16'hABCD;
        bus_op(0, 1, A_TL, 8'h00);
        n_checks++; if (io_rdata !== 8'hCD) begin n_fail++; $display("FAIL tcnt_read_lo: got %h want cd", io_rdata); end
        tcnt_count = 16'h0000;
        bus_op(0, 1, A_TH, 8'h00);
        n_checks++; if (io_rdata !== 8'hAB) begin n_fail++; $display("FAIL tcnt_read_hi: got %h want ab", io_rdata); end
        for (int i = 0; i < 10; i++) begin
            tcnt_count = 16'($urandom);
            bus_op(0, 1, A_TL, 8'h00);
            n_checks++; if (io_rdata !== m_rdata) begin n_fail++; $display("FAIL tcnt_rand_lo: got %h want %h", io_rdata, m_rdata); end
            tcnt_count = 16'($urandom);
            bus_op(0, 1, A_TH, 8'h00);
            n_checks++; if (io_rdata !== m_rdata) begin n_fail++; $display("FAIL tcnt_rand_hi: got %h want %h", io_rdata, m_rdata); end
        end
    endtask

    task automatic test_ocr();
        bus_op(1, 0, A_OCRH, 8'h01);
        n_checks++; if (OCR1AH_input !== 8'h00) begin n_fail++; $display("FAIL ocrh_only: got %h want 00", OCR1AH_input); end
        bus_op(1, 0, A_OCRL, 8'hF4);
        n_checks++; if ({OCR1AH_input, OCR1AL_input} !== 16'h01F4) begin n_fail++; $display("FAIL ocr_write: got %h want 01f4", {OCR1AH_input, OCR1AL_input}); end
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) != 0) bus_op(1, 0, A_OCRH, 8'($urandom));
            bus_op(1, 0, A_OCRL, 8'($urandom));
            n_checks++; if ({OCR1AH_input, OCR1AL_input} !== m_ocr) begin n_fail++; $display("FAIL ocr_rand: got %h want %h", {OCR1AH_input, OCR1AL_input}, m_ocr); end
            bus_op(0, 1, A_OCRH, 8'h00);
            n_checks++; if (io_rdata !== m_rdata) begin n_fail++; $display("FAIL ocrh_read: got %h want %h", io_rdata, m_rdata); end
            bus_op(0, 1, A_OCRL, 8'h00);
            n_checks++; if (io_rdata !== m_rdata) begin n_fail++; $display("FAIL ocrl_read: got %h want %h", io_rdata, m_rdata); end
        end
    endtask

    task automatic test_tccr();
        bus_op(1, 0, A_TCCR, 8'hFA);
        bus_op(0, 1, A_TCCR, 8'h00);
        n_checks++; if (io_rdata !== 8'h02) begin n_fail++; $display("FAIL tccr_read: got %h want 02", io_rdata); end
        bus_op(1, 0, A_TCCR, 8'h00);
    endtask

    task automatic test_prescaler();
        int pulses;
        int last;
        bus_op(1, 0, A_TCCR, 8'h02);
        pulses = 0;
        last = -1;
        for (int i = 0; i < 64; i++) begin
            idle_cycle();
            n_checks++; if (count_tick !== exp_tick(m_cs, cyc)) begin n_fail++; $display("FAIL div8_tick: cyc=%0d got %b want %b", cyc, count_tick, exp_tick(m_cs, cyc)); end
            if (count_tick === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    n_checks++; if (i - last != 8) begin n_fail++; $display("FAIL div8_spacing: got %0d want 8", i - last); end
                end
                last = i;
            end
        end
        n_checks++; if (pulses != 8) begin n_fail++; $display("FAIL div8_count: got %0d want 8", pulses); end
        bus_op(1, 0, A_TCCR, 8'h00);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            idle_cycle();
            if (count_tick === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL stop_count: got %0d want 0", pulses); end
        // Random clock selects, upper TCCR1B bits randomised too
        for (int k = 0; k < 6; k++) begin
            bus_op(1, 0, A_TCCR, 8'($urandom));
            n_checks++; if (count_tick !== (exp_tick(m_cs, cyc))) begin n_fail++; $display("FAIL cs_switch: cs=%0d got %b want %b", m_cs, count_tick, exp_tick(m_cs, cyc)); end
            for (int i = 0; i < 300; i++) begin
                idle_cycle();
                n_checks++; if (count_tick !== exp_tick(m_cs, cyc)) begin n_fail++; $display("FAIL cs_rand: cs=%0d cyc=%0d got %b want %b", m_cs, cyc, count_tick, exp_tick(m_cs, cyc)); end
            end
        end
        bus_op(1, 0, A_TCCR, 8'h00);
    endtask

    task automatic test_tick_suppress();
        bus_op(1, 0, A_TCCR, 8'h01);
        bus_op(1, 0, A_TH, 8'h5A);
        n_checks++; if (count_tick !== 1'b1) begin n_fail++; $display("FAIL supp_before: got %b want 1", count_tick); end
        bus_op(1, 0, A_TL, 8'hA5);
        n_checks++; if (count_tick !== 1'b0 || TCNT_write_enable !== 1'b1) begin n_fail++; $display("FAIL supp_during: tick=%b we=%b want tick=0 we=1", count_tick, TCNT_write_enable); end
        idle_cycle();
        n_checks++; if (count_tick !== 1'b1) begin n_fail++; $display("FAIL supp_after: got %b want 1", count_tick); end
        bus_op(1, 0, A_TCCR, 8'h00);
    endtask

    task automatic test_we_re_together();
        logic [7:0] d;
        bus_op(1, 0, A_TCCR, 8'h03);
        bus_op(0, 1, A_TCCR, 8'h00);
        n_checks++; if (io_rdata !== 8'h03) begin n_fail++; $display("FAIL wr_pre_read: got %h want 03", io_rdata); end
        bus_op(1, 0, A_TH, 8'h9C);
        tcnt_count = 16'h1357;
        d = 8'($urandom);
        bus_op(1, 1, A_TL, d);
        n_checks++; if (TCNT_write_enable !== 1'b1 || {TCNT1H_input, TCNT1L_input} !== {8'h9C, d}) begin n_fail++; $display("FAIL wr_preload: we=%b val=%h want we=1 val=%h", TCNT_write_enable, {TCNT1H_input, TCNT1L_input}, {8'h9C, d}); end
        n_checks++; if (io_rdata !== 8'h03) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want 03", io_rdata); end
        // TEMP must not have been overwritten by the dropped read
        bus_op(0, 1, A_TH, 8'h00);
        n_checks++; if (io_rdata !== 8'h9C) begin n_fail++; $display("FAIL wr_temp_hold: got %h want 9c", io_rdata); end
        bus_op(1, 0, A_TCCR, 8'h00);
    endtask

    task automatic test_unmatched();
        logic [15:0] ocr_before;
        bus_op(0, 1, A_OCRL, 8'h00);
        ocr_before = m_ocr;
        bus_op(0, 1, 6'h10, 8'h00);
        n_checks++; if (io_rdata !== m_rdata) begin n_fail++; $display("FAIL unm_read: got %h want %h", io_rdata, m_rdata); end
        bus_op(1, 0, 6'h3F, 8'hEE);
        n_checks++; if (TCNT_write_enable !== 1'b0 || {OCR1AH_input, OCR1AL_input} !== ocr_before) begin n_fail++; $display("FAIL unm_write: we=%b ocr=%h want we=0 ocr=%h", TCNT_write_enable, {OCR1AH_input, OCR1AL_input}, ocr_before); end
    endtask

    task automatic test_reset_midseq();
        bus_op(1, 0, A_TH, 8'h77);
        apply_reset();
        release_reset();
        bus_op(1, 0, A_TL, 8'h55);
        n_checks++; if ({TCNT1H_input, TCNT1L_input} !== 16'h0055) begin n_fail++; $display("FAIL midseq_reset: got %h want 0055", {TCNT1H_input, TCNT1L_input}); end
    endtask

`ifdef TIMER1_EXT_CLK_EN
    task automatic test_ext_clock();
        bus_op(1, 0, A_TCCR, 8'h07);
        repeat (4) idle_cycle();
        @(negedge sysClock);
        t1_pin = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge sysClock); #1;
            n_checks++; if (count_tick !== (k == 3)) begin n_fail++; $display("FAIL ext_rise: cycle %0d got %b want %b", k, count_tick, (k == 3)); end
        end
        bus_op(1, 0, A_TCCR, 8'h06);
        repeat (4) idle_cycle();
        @(negedge sysClock);
        t1_pin = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge sysClock); #1;
            n_checks++; if (count_tick !== (k == 3)) begin n_fail++; $display("FAIL ext_fall: cycle %0d got %b want %b", k, count_tick, (k == 3)); end
        end
        bus_op(1, 0, A_TCCR, 8'h00);
    endtask
`endif

    initial begin
        reset = 1'b1; io_addr = '0; io_wdata = '0; io_we = 0; io_re = 0;
        tcnt_count = '0; t1_pin = 1'b0;
        model_clear();
        test_reset();
        test_tcnt_write();
        test_tcnt_read();
        test_ocr();
        test_tccr();
        test_prescaler();
        test_tick_suppress();
        test_we_re_together();
        test_unmatched();
        test_reset_midseq();
`ifdef TIMER1_EXT_CLK_EN
        test_ext_clock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
